eo_generator: RTL and testbench

- Sequential source of numbers with a requested parity; the transmit-side counterpart of the even/odd detector.
- On a start pulse it emits a burst of `len` numbers of the requested parity (even or odd), ascending by 2 from an aligned seed.
- Output uses a valid/ready handshake and can feed the detector directly for loop-back checking.

---
 rtl/eo_pkg.sv | 16 +
 rtl/eo_seed_align.sv | 15 +
 rtl/eo_generator.sv | 107 ++++++++++
 tb/tb_eo_generator.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/eo_pkg.sv
// rtl/eo_pkg.sv - shared types and constants for the parity number generator
package eo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

  localparam int WIDTH_DEF = 8;
  localparam int LEN_W_DEF = 8;

endpackage

// File: rtl/eo_seed_align.sv
// rtl/eo_seed_align.sv - bumps a seed to the next value of the requested parity
module eo_seed_align
  import eo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] seed,
  input  logic             mode,
  output logic [WIDTH-1:0] aligned
);

  // Increment wraps modulo 2^WIDTH, so 255 aligned to even becomes 0.
  assign aligned = (seed[0] == mode) ? seed : seed + WIDTH'(1);

endmodule

// File: rtl/eo_generator.sv
// rtl/eo_generator.sv - burst source of even/odd numbers with valid/ready output
// Optional sticky parity checker: define EO_GENERATOR_SELFCHECK_EN.
module eo_generator
  import eo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [LEN_W-1:0] len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] num,
  output logic             y,
  output logic             busy,
`ifdef EO_GENERATOR_SELFCHECK_EN
  output logic             parity_err,
`endif
  output logic             done
);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             mode_q;
  logic [WIDTH-1:0] aligned;

  eo_seed_align #(.WIDTH(WIDTH)) u_align (
    .seed    (seed),
    .mode    (mode),
    .aligned (aligned)
  );

  assign y = ~num[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      num       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      mode_q    <= MODE_EVEN;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            num       <= aligned;
            remaining <= len;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= RUN;
              out_valid <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        RUN: begin
          // out_valid is always high here, so out_ready alone completes a handshake.
          if (out_ready) begin
            num       <= num + WIDTH'(2);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state     <= DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef EO_GENERATOR_SELFCHECK_EN
  logic det_even;

  assign det_even = ~num[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (state == IDLE && start) begin
      parity_err <= 1'b0;
    end else if (out_valid && (det_even == mode_q)) begin
      parity_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_eo_generator.sv
// tb/tb_eo_generator.sv - directed vector bench for eo_generator
module tb_eo_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] seed;
  logic [7:0] len;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] num;
  logic       y;
  logic       busy;
  logic       done;
`ifdef EO_GENERATOR_SELFCHECK_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  eo_generator #(.WIDTH(8), .LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .seed      (seed),
    .len       (len),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .num       (num),
    .y         (y),
    .busy      (busy),
`ifdef EO_GENERATOR_SELFCHECK_EN
    .parity_err(parity_err),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            mode;
    logic [7:0]      seed;
    logic [7:0]      len;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_burst(input logic m, input logic [7:0] s, input logic [7:0] l);
    start = 1'b1;
    mode  = m;
    seed  = s;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] e;
    logic [7:0] seen[$];
    int         hs;

    vecs[0] = '{mode: 1'b0, seed: 8'd3,   len: 8'd4, exp: {8'd10, 8'd8, 8'd6, 8'd4}};
    vecs[1] = '{mode: 1'b1, seed: 8'd252, len: 8'd3, exp: {8'd0, 8'd1, 8'd255, 8'd253}};
    vecs[2] = '{mode: 1'b0, seed: 8'd255, len: 8'd2, exp: {8'd0, 8'd0, 8'd2, 8'd0}};
    vecs[3] = '{mode: 1'b1, seed: 8'd0,   len: 8'd1, exp: {8'd0, 8'd0, 8'd0, 8'd1}};
    vecs[4] = '{mode: 1'b1, seed: 8'd6,   len: 8'd2, exp: {8'd0, 8'd0, 8'd9, 8'd7}};

    rst = 1'b1; start = 1'b0; mode = 1'b0; seed = 8'd0; len = 8'd0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset num", num, 0);
    check("reset y", y, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[v]) begin
      start_burst(vecs[v].mode, vecs[v].seed, vecs[v].len);
      for (int k = 0; k < int'(vecs[v].len); k++) begin
        e = vecs[v].exp[k];
        check($sformatf("vec%0d valid[%0d]", v, k), out_valid, 1);
        check($sformatf("vec%0d busy[%0d]", v, k), busy, 1);
        check($sformatf("vec%0d num[%0d]", v, k), num, e);
        check($sformatf("vec%0d y[%0d]", v, k), y, (e[0] == 1'b0));
        check($sformatf("vec%0d done early[%0d]", v, k), done, 0);
        @(negedge clk);
      end
      e = vecs[v].exp[vecs[v].len - 8'd1] + 8'd2;
      check($sformatf("vec%0d done", v), done, 1);
      check($sformatf("vec%0d valid after", v), out_valid, 0);
      check($sformatf("vec%0d num after", v), num, e);
      @(negedge clk);
      check($sformatf("vec%0d done single", v), done, 0);
    end

    // len 0: no value, done in the DONE cycle, then back to IDLE
    start_burst(1'b0, 8'd40, 8'd0);
    check("len0 valid", out_valid, 0);
    check("len0 done", done, 1);
    @(negedge clk);
    check("len0 valid idle", out_valid, 0);
    check("len0 done drop", done, 0);
    @(negedge clk);

    // backpressure: hold out_ready low for 3 cycles after first valid
    start_burst(1'b0, 8'd10, 8'd3);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp hold valid[%0d]", k), out_valid, 1);
      check($sformatf("bp hold num[%0d]", k), num, 10);
      @(negedge clk);
    end
    out_ready = 1'b1;
    seen.delete();
    for (int c = 0; c < 20 && !done; c++) begin
      if (out_valid && out_ready) seen.push_back(num);
      @(negedge clk);
    end
    check("bp done seen", done, 1);
    check("bp handshakes", seen.size(), 3);
    if (seen.size() == 3) begin
      check("bp seq0", seen[0], 10);
      check("bp seq1", seen[1], 12);
      check("bp seq2", seen[2], 14);
    end
    @(negedge clk);

    // start during RUN is ignored
    start_burst(1'b0, 8'd20, 8'd3);
    check("ign num0", num, 20);
    start = 1'b1; mode = 1'b1; seed = 8'd100; len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    check("ign num1", num, 22);
    @(negedge clk);
    check("ign num2", num, 24);
    check("ign valid2", out_valid, 1);
    @(negedge clk);
    check("ign done", done, 1);
    check("ign num end", num, 26);
    @(negedge clk);
    check("ign idle valid", out_valid, 0);
    @(negedge clk);

    // asynchronous reset mid-burst
    start_burst(1'b0, 8'd0, 8'd5);
    check("rstmid num0", num, 0);
    @(negedge clk);
    check("rstmid num1", num, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid valid", out_valid, 0);
    check("rstmid num", num, 0);
    check("rstmid y", y, 1);
    check("rstmid busy", busy, 0);
    check("rstmid done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_burst(1'b1, 8'd0, 8'd1);
    check("post rst valid", out_valid, 1);
    check("post rst num", num, 1);
    check("post rst y", y, 0);
    @(negedge clk);
    check("post rst done", done, 1);
    @(negedge clk);

`ifdef EO_GENERATOR_SELFCHECK_EN
    check("parity_err clear", parity_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
